frame_sched: RTL and testbench
==============================

FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 c4  in  1  4.096 MHz master clock; all logic on rising edge.
REQ-002 rst  in  1  synchronous reset, active-high.
REQ-003 f0  in  1  frame pulse, active-low, one c4 period wide, nominally every 512 c4 cycles (125 us).
REQ-004 cfg_we  in  1  config write strobe, one cycle.
REQ-005 cfg_sel  in  2  window select: 0=tx_t, 1=rx_t, 2=tx_n, 3=rx_n.
REQ-006 cfg_start  in  5  first timeslot of window (0..31).
REQ-007 cfg_end  in  5  last timeslot of window, inclusive.
REQ-008 cfg_en  in  1  window enable.
REQ-009 clk_en_tx_t, clk_en_rx_t, clk_en_tx_n, clk_en_rx_n  out  1 each  timeslot-window enables for the converter.
REQ-010 ts  out  5  current timeslot; bitn  out  3  current bit; phase  out  1  half-bit phase.
REQ-011 locked  out  1  frame alignment held.
REQ-012 frame_start  out  1  one-cycle pulse at frame count 0 while locked.
REQ-013 frame_err  out  1  one-cycle pulse on alignment fault.

Function
REQ-014 9-bit frame counter cnt SHALL reload to 0 in the cycle after f0 is sampled low (search/resync), else increment modulo 512.
REQ-015 ts = cnt[8:4], bitn = cnt[3:1], phase = cnt[0], all registered and driven from cnt in the same cycle.
REQ-016 FSM states SEARCH, VERIFY, LOCKED.
REQ-017 SEARCH: f0 sampled low -> cnt reloads to 0, go VERIFY; otherwise cnt held at 0.
REQ-018 VERIFY: f0 sampled low exactly at cnt==511 -> LOCKED; f0 low at any other cnt -> reload cnt to 0, stay VERIFY; cnt==511 with f0 high -> SEARCH.
REQ-019 LOCKED: f0 low at cnt==511 -> clear miss counter; f0 high at cnt==511 -> increment 1-bit miss counter, cnt wraps normally (flywheel).
REQ-020 LOCKED: second consecutive miss -> SEARCH, frame_err pulse, locked falls next cycle.
REQ-021 LOCKED: f0 low at cnt!=511 -> frame_err pulse, reload cnt to 0, go VERIFY.
REQ-022 locked = 1 only in LOCKED; frame_start = LOCKED and cnt==0.
REQ-023 Each window has a shadow register {en,start,end} written by cfg_we/cfg_sel; multiple writes in one frame, last wins.
REQ-024 Shadow copied to active config when cnt wraps 511->0 in LOCKED; a write in the cnt==511 cycle SHALL be included in that copy.
REQ-025 Outside LOCKED, shadow copied to active every cycle (config effective immediately).
REQ-026 clk_en_x = locked AND active en AND ts in window; window is start..end if start<=end, else start..31 plus 0..end (wrap).
REQ-027 start==end selects exactly one timeslot (16 c4 cycles).
REQ-028 clk_en_x SHALL be registered and aligned with the ts value it decodes (no extra latency versus ts).
REQ-029 All four enables SHALL drop to 0 in the first cycle locked is 0.

Reset
REQ-030 rst high at a rising c4 edge: state SEARCH, cnt 0, miss counter 0, shadow and active config {en=0,start=0,end=0}.
REQ-031 During and one cycle after reset: all outputs 0 (ts, bitn, phase, locked, frame_start, frame_err, clk_en_*).
REQ-032 Reset mid-frame or mid-write discards the write and all alignment; f0 sampled during rst is ignored.

Verification
REQ-033 f0 pulses every 512 cycles from reset -> locked=1 in the cycle after the second pulse; frame_start every 512 cycles; ts 0..31 each held 16 cycles.
REQ-034 tx_t window start=2,end=4,en=1 while locked -> clk_en_tx_t high exactly for cnt 32..79 of the following frame, not the current one.
REQ-035 rx_n start=30,end=1 -> clk_en_rx_n high for cnt 480..511 and 0..31.
REQ-036 Drop one f0 pulse -> locked stays 1, no frame_err; drop two consecutive -> frame_err pulse, locked 0, all enables 0.
REQ-037 While locked, inject f0 low at cnt==200 -> frame_err pulse, cnt 0 next cycle, locked 0; next pulse 512 cycles later -> locked 1.
REQ-038 Assert rst for 1 cycle while locked with windows enabled -> all outputs 0, config cleared, relock requires two f0 pulses.

Source files
------------

// File: rtl/frame_sched.sv
// Frame aligner with flywheel and per-timeslot converter enables.
// All outputs are registered and clk_en_* line up with ts. Free-running on c4, with no backpressure.
module frame_sched (
  input  logic       c4,
  input  logic       rst,
  input  logic       f0,
  input  logic       cfg_we,
  input  logic [1:0] cfg_sel,
  input  logic [4:0] cfg_start,
  input  logic [4:0] cfg_end,
  input  logic       cfg_en,
  output logic       clk_en_tx_t,
  output logic       clk_en_rx_t,
  output logic       clk_en_tx_n,
  output logic       clk_en_rx_n,
  output logic [4:0] ts,
  output logic [2:0] bitn,
  output logic       phase,
  output logic       locked,
  output logic       frame_start,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef struct packed {
    logic       en;
    logic [4:0] start;
    logic [4:0] stop;
  } win_t;

  state_t     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic       miss_q, miss_d;
  logic       frame_err_q, frame_err_d;
  win_t [3:0] shadow_q, shadow_d;
  win_t [3:0] active_q, active_d;
  logic [3:0] clk_en_q, clk_en_d;
  logic       at_end;

  assign at_end = (cnt_q == 9'd511);

  function automatic logic in_window(input logic [4:0] slot, input win_t w);
    logic hit;
    if (w.start <= w.stop) hit = (slot >= w.start) && (slot <= w.stop);
    else                   hit = (slot >= w.start) || (slot <= w.stop);
    return hit;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 9'd1;
    miss_d      = miss_q;
    frame_err_d = 1'b0;
    case (state_q)
      SEARCH: begin
        cnt_d = '0;
        if (!f0) state_d = VERIFY;
      end
      VERIFY: begin
        if (!f0) begin
          cnt_d = '0;
          if (at_end) state_d = LOCKED;
        end else if (at_end) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (!f0 && !at_end) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          miss_d      = 1'b0;
          state_d     = VERIFY;
        end else if (at_end) begin
          // Missing pulse: flywheel through one frame, give up on the second.
          if (!f0) begin
            miss_d = 1'b0;
          end else if (miss_q) begin
            miss_d      = 1'b0;
            frame_err_d = 1'b1;
            state_d     = SEARCH;
          end else begin
            miss_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = SEARCH;
        cnt_d   = '0;
        miss_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we) begin
      shadow_d[cfg_sel].en    = cfg_en;
      shadow_d[cfg_sel].start = cfg_start;
      shadow_d[cfg_sel].stop  = cfg_end;
    end
    // Copy from shadow_d so that a write landing on the wrap cycle takes effect in the next frame.
    active_d = active_q;
    if ((state_q != LOCKED) || at_end) active_d = shadow_d;
    clk_en_d = '0;
    for (int i = 0; i < 4; i++) begin
      clk_en_d[i] = (state_d == LOCKED) && active_d[i].en && in_window(cnt_d[8:4], active_d[i]);
    end
  end

  always_ff @(posedge c4) begin
    if (rst) begin
      state_q     <= SEARCH;
      cnt_q       <= '0;
      miss_q      <= 1'b0;
      frame_err_q <= 1'b0;
      shadow_q    <= '0;
      active_q    <= '0;
      clk_en_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      frame_err_q <= frame_err_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      clk_en_q    <= clk_en_d;
    end
  end

  assign ts          = cnt_q[8:4];
  assign bitn        = cnt_q[3:1];
  assign phase       = cnt_q[0];
  assign locked      = (state_q == LOCKED);
  assign frame_start = locked && (cnt_q == 9'd0);
  assign frame_err   = frame_err_q;
  assign clk_en_tx_t = clk_en_q[0];
  assign clk_en_rx_t = clk_en_q[1];
  assign clk_en_tx_n = clk_en_q[2];
  assign clk_en_rx_n = clk_en_q[3];

endmodule

// File: tb/tb_frame_sched.sv
// Directed bench for frame_sched: alignment, flywheel, faults, window decode and reset.
module tb_frame_sched;

  logic       c4;
  logic       rst;
  logic       f0;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [4:0] cfg_start;
  logic [4:0] cfg_end;
  logic       cfg_en;
  logic       clk_en_tx_t, clk_en_rx_t, clk_en_tx_n, clk_en_rx_n;
  logic [4:0] ts;
  logic [2:0] bitn;
  logic       phase;
  logic       locked;
  logic       frame_start;
  logic       frame_err;
  logic [3:0] en_bus;

  int checks = 0;
  int errors = 0;

  // In-frame config writes (cnt at which to write, -1 = unused).
  int wr_k[3];
  int wr_sel[3];
  int wr_s[3];
  int wr_e[3];
  bit wr_en[3];
  // Expected enable ranges in cnt units for tx_t, rx_t, tx_n, rx_n (lo > hi wraps).
  int ex_lo[4];
  int ex_hi[4];
  bit ex_on[4];

  frame_sched dut (
    .c4          (c4),
    .rst         (rst),
    .f0          (f0),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_start   (cfg_start),
    .cfg_end     (cfg_end),
    .cfg_en      (cfg_en),
    .clk_en_tx_t (clk_en_tx_t),
    .clk_en_rx_t (clk_en_rx_t),
    .clk_en_tx_n (clk_en_tx_n),
    .clk_en_rx_n (clk_en_rx_n),
    .ts          (ts),
    .bitn        (bitn),
    .phase       (phase),
    .locked      (locked),
    .frame_start (frame_start),
    .frame_err   (frame_err)
  );

  assign en_bus = {clk_en_rx_n, clk_en_tx_n, clk_en_rx_t, clk_en_tx_t};

  initial c4 = 1'b0;
  always #5 c4 = ~c4;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge c4);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_f0();
    f0 = 1'b0;
    tick();
    f0 = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, 32'({ts, bitn, phase, locked, frame_start, frame_err, en_bus}), 32'd0);
  endtask

  task automatic clear_writes();
    for (int w = 0; w < 3; w++) wr_k[w] = -1;
  endtask

  task automatic set_exp(input int i, input bit on, input int lo, input int hi);
    ex_on[i] = on;
    ex_lo[i] = lo;
    ex_hi[i] = hi;
  endtask

  function automatic bit exp_en(input int i, input int k);
    if (!ex_on[i]) return 1'b0;
    if (ex_lo[i] <= ex_hi[i]) return (k >= ex_lo[i]) && (k <= ex_hi[i]);
    return (k >= ex_lo[i]) || (k <= ex_hi[i]);
  endfunction

  // Walks one full locked frame starting at cnt 0, checking every cycle.
  task automatic run_frame(input string tag, input bit send_f0);
    int n_cnt, n_fs, n_en, n_lk, n_fe;
    logic [3:0] en_exp;
    n_cnt = 0; n_fs = 0; n_en = 0; n_lk = 0; n_fe = 0;
    for (int k = 0; k < 512; k++) begin
      if ({ts, bitn, phase} !== 9'(k)) n_cnt++;
      for (int i = 0; i < 4; i++) en_exp[i] = exp_en(i, k);
      if (en_bus !== en_exp) n_en++;
      if (frame_start !== (k == 0)) n_fs++;
      if (locked !== 1'b1) n_lk++;
      if (frame_err !== 1'b0) n_fe++;
      for (int w = 0; w < 3; w++) begin
        if (wr_k[w] == k) begin
          cfg_we    = 1'b1;
          cfg_sel   = 2'(wr_sel[w]);
          cfg_start = 5'(wr_s[w]);
          cfg_end   = 5'(wr_e[w]);
          cfg_en    = wr_en[w];
        end
      end
      f0 = !(send_f0 && (k == 511));
      tick();
      cfg_we = 1'b0;
      f0     = 1'b1;
    end
    check_eq({tag, "_cnt"}, 32'(n_cnt), 32'd0);
    check_eq({tag, "_en"}, 32'(n_en), 32'd0);
    check_eq({tag, "_fstart"}, 32'(n_fs), 32'd0);
    check_eq({tag, "_locked"}, 32'(n_lk), 32'd0);
    check_eq({tag, "_ferr"}, 32'(n_fe), 32'd0);
  endtask

  initial begin
    rst = 1'b1; f0 = 1'b1; cfg_we = 1'b0; cfg_sel = '0;
    cfg_start = '0; cfg_end = '0; cfg_en = 1'b0;
    clear_writes();
    for (int i = 0; i < 4; i++) set_exp(i, 1'b0, 0, 0);

    // Reset, with an f0 pulse inside reset that must be ignored.
    run(2);
    check_all_zero("reset_outs");
    f0 = 1'b0;
    tick();
    rst = 1'b0; f0 = 1'b1;
    tick();
    check_all_zero("post_reset_outs");
    run(20);
    check_eq("search_hold", 32'(ts), 32'd0);

    // rx_n window 30..1, written before lock, so it is effective immediately.
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_start = 5'd30; cfg_end = 5'd1; cfg_en = 1'b1;
    tick();
    cfg_we = 1'b0;
    check_eq("unlocked_en", 32'(en_bus), 32'd0);

    // VERIFY times out without the second pulse.
    pulse_f0();
    run(511);
    check_eq("verify_cnt", 32'(ts), 32'd31);
    tick();
    run(20);
    check_eq("verify_to_search", 32'(ts), 32'd0);

    // Early pulse in VERIFY restarts the count, and the next on-time pulse locks.
    pulse_f0();
    run(99);
    pulse_f0();
    check_eq("verify_reload", 32'({locked, ts}), 32'd0);
    run(511);
    check_eq("pre_lock", 32'(locked), 32'd0);
    pulse_f0();
    check_eq("lock", 32'(locked), 32'd1);

    // Frame A: writes take effect only after the wrap, and the last write wins.
    set_exp(3, 1'b1, 480, 31);
    wr_k[0] = 100; wr_sel[0] = 0; wr_s[0] = 10; wr_e[0] = 12; wr_en[0] = 1'b1;
    wr_k[1] = 200; wr_sel[1] = 0; wr_s[1] = 2;  wr_e[1] = 4;  wr_en[1] = 1'b1;
    wr_k[2] = 511; wr_sel[2] = 2; wr_s[2] = 5;  wr_e[2] = 5;  wr_en[2] = 1'b1;
    run_frame("frame_a", 1'b1);
    clear_writes();

    // Frames B..E: single miss is tolerated, a pulse clears it, two in a row fault.
    set_exp(0, 1'b1, 32, 79);
    set_exp(2, 1'b1, 80, 95);
    run_frame("frame_b", 1'b0);
    run_frame("frame_c", 1'b1);
    run_frame("frame_d", 1'b0);
    run_frame("frame_e", 1'b0);
    check_eq("dbl_miss_err", 32'(frame_err), 32'd1);
    check_eq("dbl_miss_unlock", 32'({locked, en_bus}), 32'd0);
    tick();
    check_eq("err_one_cycle", 32'(frame_err), 32'd0);

    // Relock, then inject a misplaced pulse at cnt 200.
    pulse_f0();
    run(511);
    pulse_f0();
    check_eq("relock", 32'(locked), 32'd1);
    check_eq("en_cnt0", 32'(en_bus), 32'b1000);
    run(200);
    check_eq("ts_200", 32'(ts), 32'd12);
    pulse_f0();
    check_eq("inject_err", 32'(frame_err), 32'd1);
    check_eq("inject_state", 32'({locked, ts, en_bus}), 32'd0);
    tick();
    check_eq("inject_err_clr", 32'(frame_err), 32'd0);
    run(510);
    check_eq("inject_pre", 32'({locked, ts}), 32'd31);
    pulse_f0();
    check_eq("inject_relock", 32'({locked, frame_start}), 32'b11);
    run(50);
    check_eq("en_cnt50", 32'(en_bus), 32'b0001);

    // Reset while locked, with a concurrent write that must be discarded.
    rst = 1'b1;
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_start = 5'd0; cfg_end = 5'd31; cfg_en = 1'b1;
    tick();
    check_all_zero("rst_outs");
    rst = 1'b0; cfg_we = 1'b0;
    tick();
    check_all_zero("rst_post");
    pulse_f0();
    run(511);
    check_eq("rst_prelock", 32'(locked), 32'd0);
    pulse_f0();
    check_eq("rst_relock", 32'(locked), 32'd1);
    check_eq("cfg_cleared0", 32'(en_bus), 32'd0);
    run(50);
    check_eq("cfg_cleared50", 32'(en_bus), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
